// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU-to-Wishbone bridge.
package cpu_bus_pkg;

    // Bridge transaction phases.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    // Read data returned alongside an error response.
    localparam logic [31:0] WB_ERR_DATA = 32'hFFFF_FFFF;

    // Width of the watchdog counter; it only has to reach cycles-1.
    function automatic int timeout_cnt_width(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/cpu_wb_bridge_if.sv
// CPU request/response handshake and pipelined Wishbone master signals.
//
// CPU handshake: a request transfers on the rising edge where
// i_req_valid && o_req_ready. The CPU holds all request fields stable
// while i_req_valid is high and o_req_ready is low. The response is a
// single-cycle o_rsp_valid pulse with no back-pressure; o_rsp_err
// qualifies it.
//
// The slave modport is the bridge's own view. The master modport is the
// view of everything around it: the CPU and the Wishbone slave.
interface cpu_wb_bridge_if
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) ();
    // CPU side
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_we;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic [31:0]           i_req_wdata;
    logic [3:0]            i_req_sel;
    logic                  o_rsp_valid;
    logic [31:0]           o_rsp_rdata;
    logic                  o_rsp_err;
    // Wishbone side
    logic                  o_cyc;
    logic                  o_stb;
    logic                  o_we;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [31:0]           o_data;
    logic [3:0]            o_sel;
    logic                  i_stall;
    logic                  i_ack;
    logic [31:0]           i_data;
    // Current FSM phase, for observation only
    state_t                dbg_state;

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_sel,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_cyc, o_stb, o_we, o_addr, o_data, o_sel,
        input  i_stall, i_ack, i_data,
        output dbg_state
    );

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_sel,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_cyc, o_stb, o_we, o_addr, o_data, o_sel,
        output i_stall, i_ack, i_data,
        input  dbg_state
    );
endinterface

// File: rtl/cpu_wb_bridge.sv
// Single-outstanding bridge from the CPU load/store unit to pipelined
// Wishbone, with a watchdog that converts a missing ack into an error.
module cpu_wb_bridge
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic             i_clk,
    input logic             i_rst,
    cpu_wb_bridge_if.slave  bus
);

    localparam int             CNT_W    = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [3:0]            sel_q, sel_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  timeout;

    // Watchdog fires on the last permitted cycle of a transaction.
    assign timeout = (cnt_q == CNT_LAST);

    // Register every bus/response field; reset abandons any transaction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and next-output logic; fields hold unless a phase changes them.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        sel_d       = sel_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req_valid) begin
                    we_d    = bus.i_req_we;
                    addr_d  = bus.i_req_addr;
                    data_d  = bus.i_req_wdata;
                    sel_d   = bus.i_req_sel;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // An ack here cannot belong to this request, so it is ignored.
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = WB_ERR_DATA;
                    state_d     = IDLE;
                end else if (!bus.i_stall) begin
                    stb_d   = 1'b0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                cnt_d = cnt_q + 1'b1;
                // A real ack beats a watchdog expiring in the same cycle.
                if (bus.i_ack) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? 32'h0 : bus.i_data;
                    state_d     = IDLE;
                end else if (timeout) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = WB_ERR_DATA;
                    state_d     = IDLE;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_req_ready = (state_q == IDLE);
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_cyc       = cyc_q;
    assign bus.o_stb       = stb_q;
    assign bus.o_we        = we_q;
    assign bus.o_addr      = addr_q;
    assign bus.o_data      = data_q;
    assign bus.o_sel       = sel_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: doc/cpu_wb_bridge.md
Name: cpu_wb_bridge

Overview:
Single-outstanding bridge between the CPU load/store unit and the pipelined Wishbone bus that serves the UART, RAM and peripherals. It accepts one CPU memory request over a valid/ready handshake and issues one Wishbone transaction, honouring stall. It returns read data or an error through a one-cycle response pulse. A watchdog turns a missing ack into an error so the CPU never hangs on an unmapped or dead slave.

Parameters:
ADDR_WIDTH, 32, width of the CPU and Wishbone byte address.
TIMEOUT_CYCLES, 1024, cycles from STB assertion to forced error if no ack arrives; must be ≥ 2.

Ports:
i_clk  in  1  system clock; everything is sampled on its rising edge.
i_rst  in  1  synchronous, active-high reset.
i_req_valid  in  1  CPU request present.
o_req_ready  out  1  bridge can accept a request (combinational: state==IDLE).
i_req_we  in  1  1 = store, 0 = load.
i_req_addr  in  ADDR_WIDTH  byte address, passed through unmodified.
i_req_wdata  in  32  store data.
i_req_sel  in  4  byte lane enables.
o_rsp_valid  out  1  one-cycle response pulse.
o_rsp_rdata  out  32  load data; all-ones on error; 0 for stores.
o_rsp_err  out  1  qualifies o_rsp_valid; timeout occurred.
o_cyc  out  1  Wishbone CYC.
o_stb  out  1  Wishbone STB.
o_we  out  1  Wishbone WE.
o_addr  out  ADDR_WIDTH  Wishbone address.
o_data  out  32  Wishbone write data.
o_sel  out  4  Wishbone byte select.
i_stall  in  1  Wishbone STALL.
i_ack  in  1  Wishbone ACK.
i_data  in  32  Wishbone read data.

Behaviour:
- Clock is i_clk; reset is i_rst, synchronous, active-high.
- Reset values: state IDLE, o_cyc=o_stb=o_we=0, o_addr=0, o_data=0, o_sel=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, timeout counter=0.
- All bus and response outputs are registered. Only o_req_ready is combinational.
- IDLE:
  - On i_req_valid && o_req_ready, capture we/addr/wdata/sel into o_we/o_addr/o_data/o_sel.
  - Set o_cyc=o_stb=1, clear the counter, go to REQ.
  - o_rsp_valid is forced to 0 every cycle unless set below.
- REQ:
  - While i_stall=1, hold o_stb and all fields stable.
  - When i_stall=0 the request is accepted that cycle. Next cycle o_stb=0, o_cyc stays 1, go to WAIT_ACK.
  - i_ack seen in REQ is ignored.
- WAIT_ACK:
  - On i_ack: next cycle o_cyc=0, o_rsp_valid=1, o_rsp_err=0, state IDLE.
  - o_rsp_rdata is i_data for a load and 0 for a store.
- Timeout:
  - The counter increments every cycle in REQ and WAIT_ACK.
  - If it equals TIMEOUT_CYCLES-1 and i_ack=0 that cycle: next cycle o_cyc=o_stb=0, o_rsp_valid=1, o_rsp_err=1, o_rsp_rdata=32'hFFFF_FFFF, state IDLE.
  - If i_ack coincides with the timeout cycle, the ack wins (normal response).
- Throughput and latency:
  - At most one outstanding transaction.
  - A new request may be accepted in the same cycle o_rsp_valid=1, since state is already IDLE.
  - Minimum latency, with a registered-ack slave and no stall: accept at t0, STB at t1, ACK at t2, o_rsp_valid at t3.
- Reset mid-transaction: CYC/STB drop on the next edge, no response is generated, and the captured request is discarded.
- o_req_ready=0 in REQ and WAIT_ACK. The CPU must hold its request stable until accepted.

Decomposition:
- Shared package cpu_bus_pkg:
  - state enum {IDLE, REQ, WAIT_ACK};
  - WB_ERR_DATA = 32'hFFFF_FFFF;
  - timeout counter width = $clog2(TIMEOUT_CYCLES).
- No sub-module; the timeout counter is inline.

Test Plan:
- Load, no stall: request addr 0x1000_0000, slave acks at t2 with i_data=0x0000_0041 -> o_rsp_valid at t3 with rdata 0x41, err 0; o_stb high exactly 1 cycle.
- Store with stall: we=1, wdata 0x55, sel 4'b0001, i_stall held 3 cycles -> o_stb high 4 cycles, fields stable throughout; ack -> rsp_valid, rdata 0, err 0.
- Timeout: TIMEOUT_CYCLES=16, never ack -> o_cyc drops and rsp_valid/err=1, rdata 0xFFFF_FFFF exactly 16 cycles after STB rises.
- Ack on the timeout cycle: ack arrives exactly on counter 15 -> normal response, err 0.
- Back-to-back: second request asserted while the first response pulses -> accepted that cycle, next STB one cycle later.
- Reset in WAIT_ACK: assert i_rst for 1 cycle -> o_cyc=0 next cycle, no o_rsp_valid; a later ack is ignored and o_req_ready=1.
